// File: rtl/scan_seg_rx.sv
// scan_seg_rx: receiver for a multiplexed, active-low 7-segment clock display.
// It samples the digit-select and segment buses, waits for them to hold steady,
// then decodes which digit is being driven and which numeral it shows.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   dsel_n[7:0]         digit select, active-low
//                       (bit0 sec0, bit1 sec1, bit3 min0, bit4 min1,
//                        bit6 hour0, bit7 hour1; bits 2 and 5 are unmapped)
//   seg_n[7:0]          segment bus, active-low (bit7 DP, bits6:0 segments g..a)
//   sec0..hour1[3:0]    last decoded value per digit position (4'hF = blank)
//   digit_vld[5:0]      set once a position has been written (sec0..hour1)
//   dp[5:0]             decimal-point state from the last write to each position
//   frame_done          one-cycle pulse when all six positions have been written
//   seg_err             one-cycle pulse on an undecodable segment pattern
//   sel_err             one-cycle pulse on an illegal select pattern
//   err_cnt[7:0]        saturating count of seg_err and sel_err pulses
module scan_seg_rx #(
  parameter int unsigned STABLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dsel_n,
  input  logic [7:0] seg_n,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic [3:0] hour0,
  output logic [3:0] hour1,
  output logic [5:0] digit_vld,
  output logic [5:0] dp,
  output logic       frame_done,
  output logic       seg_err,
  output logic       sel_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned BUS_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NPOS  = 6;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned ERR_W = 8;

  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  localparam logic [BUS_W-1:0] BUS_IDLE = '1;

  // Registered state
  logic [BUS_W-1:0]            s_reg_q, s_reg_d;
  logic [BUS_W-1:0]            s_prev_q, s_prev_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NPOS-1:0]             mask_q, mask_d;
  logic [NPOS-1:0][VAL_W-1:0]  val_q, val_d;
  logic [NPOS-1:0]             vld_q, vld_d;
  logic [NPOS-1:0]             dp_q, dp_d;
  logic                        frame_done_q, frame_done_d;
  logic                        seg_err_q, seg_err_d;
  logic                        sel_err_q, sel_err_d;
  logic [ERR_W-1:0]            err_cnt_q, err_cnt_d;

  // Decode helpers
  logic [7:0]       sel_n;
  logic [6:0]       segs;
  logic [NPOS-1:0]  pos_oh;
  logic             sel_blank;
  logic             sel_legal;
  logic [VAL_W-1:0] seg_val;
  logic             seg_ok;
  logic             changed;
  logic             accept;
  logic             err_evt;
  logic [NPOS-1:0]  mask_nxt;

  // Select and segment decode of the registered sample
  always_comb begin
    sel_n     = s_reg_q[15:8];
    segs      = ~s_reg_q[6:0];
    pos_oh    = {~sel_n[7], ~sel_n[6], ~sel_n[4], ~sel_n[3], ~sel_n[1], ~sel_n[0]};
    sel_blank = (sel_n == 8'hFF);
    // Unmapped bits must stay high and exactly one mapped bit may be low
    sel_legal = sel_n[2] && sel_n[5] && $onehot(pos_oh);
    seg_ok    = 1'b1;
    seg_val   = 4'h0;
    case (segs)
      7'b0111111: seg_val = 4'd0;
      7'b0000110: seg_val = 4'd1;
      7'b1011011: seg_val = 4'd2;
      7'b1001111: seg_val = 4'd3;
      7'b1100110: seg_val = 4'd4;
      7'b1101101: seg_val = 4'd5;
      7'b1111101: seg_val = 4'd6;
      7'b0100111: seg_val = 4'd7;
      7'b1111111: seg_val = 4'd8;
      7'b1100111: seg_val = 4'd9;
      7'b0000000: seg_val = 4'hF;
      default: begin
        seg_val = 4'h0;
        seg_ok  = 1'b0;
      end
    endcase
  end

  // Next-state logic: stability filter, write/error handling, frame tracking
  always_comb begin
    s_reg_d      = {dsel_n, seg_n};
    s_prev_d     = s_reg_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    val_d        = val_q;
    vld_d        = vld_q;
    dp_d         = dp_q;
    frame_done_d = 1'b0;
    seg_err_d    = 1'b0;
    sel_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    err_evt      = 1'b0;
    mask_nxt     = mask_q;

    changed = (s_reg_q != s_prev_q);
    if (changed) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q < CNT_TGT) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Accept only on the cycle the count first lands on the target
    accept = (cnt_d == CNT_TGT) && (changed || (cnt_q != CNT_TGT));

    if (accept && !sel_blank) begin
      if (!sel_legal) begin
        sel_err_d = 1'b1;
        err_evt   = 1'b1;
      end else if (!seg_ok) begin
        seg_err_d = 1'b1;
        err_evt   = 1'b1;
      end else begin
        for (int i = 0; i < int'(NPOS); i++) begin
          if (pos_oh[i]) begin
            val_d[i] = seg_val;
            dp_d[i]  = ~s_reg_q[7];
            vld_d[i] = 1'b1;
          end
        end
        mask_nxt = mask_q | pos_oh;
        if (&mask_nxt) begin
          frame_done_d = 1'b1;
          mask_d       = '0;
        end else begin
          mask_d       = mask_nxt;
        end
      end
    end

    if (err_evt && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_reg_q      <= BUS_IDLE;
      s_prev_q     <= BUS_IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      val_q        <= '0;
      vld_q        <= '0;
      dp_q         <= '0;
      frame_done_q <= 1'b0;
      seg_err_q    <= 1'b0;
      sel_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      s_reg_q      <= s_reg_d;
      s_prev_q     <= s_prev_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      val_q        <= val_d;
      vld_q        <= vld_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
      seg_err_q    <= seg_err_d;
      sel_err_q    <= sel_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign sec0       = val_q[0];
  assign sec1       = val_q[1];
  assign min0       = val_q[2];
  assign min1       = val_q[3];
  assign hour0      = val_q[4];
  assign hour1      = val_q[5];
  assign digit_vld  = vld_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
  assign seg_err    = seg_err_q;
  assign sel_err    = sel_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
